// File: rtl/weight_load_controller.sv
// weight_load_controller
//   Loads one kernel at a time into the weight buffer for the weight-stationary
//   dataflow. For each filter it clears the buffer, streams K = WEIGHT_HEIGHT *
//   WEIGHT_WIDTH words from the AXI side, appends one zero flush word, waits
//   for wb_ready, then presents weights_valid until the consumer reports
//   compute_done. A job of num_filters filters ends with a one-cycle done.
//
//   Optional feature: define WLC_WATCHDOG_EN to add a watchdog on the two wait
//   states. After TIMEOUT_CYCLES cycles in one wait state it raises a sticky
//   error and returns to IDLE. Without the macro, error is tied 0.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   start, num_filters  job start pulse and filter count (sampled in IDLE)
//   s_data/s_valid/s_ready    weight word stream from the AXI side
//   wb_data_in, wb_write_enable, wb_clear, wb_ready   weight buffer interface
//   weights_valid, compute_done   handshake with the preprocessing unit
//   filter_idx          index of the filter being loaded or issued
//   busy, done, error   status
module weight_load_controller #(
  parameter int WIDTH           = 4,
  parameter int WEIGHT_HEIGHT   = 3,
  parameter int WEIGHT_WIDTH    = 3,
  parameter int NUM_FILTERS_MAX = 16,
  parameter int FCNT_W          = 5,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [FCNT_W-1:0] num_filters,
  input  logic [31:0]       s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [31:0]       wb_data_in,
  output logic              wb_write_enable,
  output logic              wb_clear,
  input  logic              wb_ready,
  output logic              weights_valid,
  input  logic              compute_done,
  output logic [FCNT_W-1:0] filter_idx,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int K      = WEIGHT_HEIGHT * WEIGHT_WIDTH;
  localparam int WCNT_W = $clog2(K + 1);
  localparam logic [WCNT_W-1:0] K_LAST = WCNT_W'(K - 1);
  localparam logic [FCNT_W-1:0] NF_MAX = FCNT_W'(NUM_FILTERS_MAX);

  // Elaboration-time sanity on the parameter set.
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("WIDTH must be 1..32");
  end
  if (K < 1) begin : g_bad_kernel
    $error("kernel must hold at least one weight");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [2:0] {
    IDLE, CLEAR, LOAD, FLUSH, WAIT_READY, ISSUE, WAIT_DONE, DONE
  } state_t;

  state_t              state;
  logic [WCNT_W-1:0]   word_cnt;
  logic [FCNT_W-1:0]   nf;
  logic [FCNT_W-1:0]   nf_req;
  logic [FCNT_W:0]     idx_nxt;
  logic                hs;

  assign hs      = s_valid && s_ready;
  assign busy    = (state != IDLE);
  assign nf_req  = (num_filters > NF_MAX) ? NF_MAX : num_filters;
  // One bit wider so the compare with nf cannot wrap.
  assign idx_nxt = {1'b0, filter_idx} + {{FCNT_W{1'b0}}, 1'b1};

`ifdef WLC_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_cnt;
  logic            in_wait;
  logic            leaving;
  assign in_wait = (state == WAIT_READY) || (state == WAIT_DONE);
  // A legitimate exit in the same cycle as expiry wins over the timeout.
  assign leaving = ((state == WAIT_READY) && wb_ready) ||
                   ((state == WAIT_DONE) && compute_done);
`else
  assign error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      word_cnt        <= '0;
      nf              <= '0;
      s_ready         <= 1'b0;
      wb_data_in      <= '0;
      wb_write_enable <= 1'b0;
      wb_clear        <= 1'b0;
      weights_valid   <= 1'b0;
      filter_idx      <= '0;
      done            <= 1'b0;
`ifdef WLC_WATCHDOG_EN
      wd_cnt          <= '0;
      error           <= 1'b0;
`endif
    end else begin
      wb_write_enable <= 1'b0;
      wb_clear        <= 1'b0;
      done            <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            nf         <= nf_req;
            filter_idx <= '0;
            state      <= (nf_req == '0) ? DONE : CLEAR;
          end
        end
        CLEAR: begin
          wb_clear <= 1'b1;
          word_cnt <= '0;
          s_ready  <= 1'b1;
          state    <= LOAD;
        end
        LOAD: begin
          if (hs) begin
            wb_write_enable <= 1'b1;
            wb_data_in      <= s_data;
            word_cnt        <= word_cnt + WCNT_W'(1);
            if (word_cnt == K_LAST) begin
              s_ready <= 1'b0;
              state   <= FLUSH;
            end
          end
        end
        FLUSH: begin
          // The buffer's shift path lags one word; this zero pushes the
          // last real weight into place and triggers wb_ready.
          wb_write_enable <= 1'b1;
          wb_data_in      <= '0;
          state           <= WAIT_READY;
        end
        WAIT_READY: begin
          if (wb_ready) state <= ISSUE;
        end
        ISSUE: begin
          weights_valid <= 1'b1;
          state         <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (compute_done) begin
            weights_valid <= 1'b0;
            if (idx_nxt < {1'b0, nf}) begin
              filter_idx <= idx_nxt[FCNT_W-1:0];
              state      <= CLEAR;
            end else begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          done       <= 1'b1;
          filter_idx <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase

`ifdef WLC_WATCHDOG_EN
      if (!in_wait || leaving) begin
        wd_cnt <= '0;
      end else if (wd_cnt == WD_LAST) begin
        error         <= 1'b1;
        weights_valid <= 1'b0;
        filter_idx    <= '0;
        wd_cnt        <= '0;
        state         <= IDLE;
      end else begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end
`endif
    end
  end

endmodule

// File: tb/tb_weight_load_controller.sv
module tb_weight_load_controller;
  localparam int K = 9;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  num_filters;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] wb_data_in;
  logic        wb_write_enable;
  logic        wb_clear;
  logic        wb_ready;
  logic        weights_valid;
  logic        compute_done;
  logic [4:0]  filter_idx;
  logic        busy;
  logic        done;
  logic        error;

  int vectors = 0;
  int errors  = 0;

  logic [31:0] exp_wr[$];
  logic [31:0] exp_clr[$];
  logic [31:0] exp_iss[$];
  logic [31:0] exp_done[$];

  logic       hold_nr = 1'b0;
  logic [4:0] mcnt;
  logic       wv_d;

  weight_load_controller dut (
    .clk(clk), .reset(reset), .start(start), .num_filters(num_filters),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .wb_data_in(wb_data_in), .wb_write_enable(wb_write_enable),
    .wb_clear(wb_clear), .wb_ready(wb_ready), .weights_valid(weights_valid),
    .compute_done(compute_done), .filter_idx(filter_idx), .busy(busy),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Weight buffer model: ready rises after its (K+1)th write, sticky until clear.
  always @(posedge clk) begin
    if (reset || wb_clear) begin
      mcnt     <= '0;
      wb_ready <= 1'b0;
    end else if (wb_write_enable) begin
      mcnt <= mcnt + 5'd1;
      if (mcnt + 5'd1 == 5'(K + 1) && !hold_nr) wb_ready <= 1'b1;
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    wv_d <= weights_valid;
    if (wb_write_enable) begin
      check("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
      if (exp_wr.size() != 0) check("wr_data", wb_data_in, exp_wr.pop_front());
    end
    if (wb_clear) begin
      check("clr_expected", 32'(exp_clr.size() != 0), 32'd1);
      if (exp_clr.size() != 0) check("clr_idx", 32'(filter_idx), exp_clr.pop_front());
    end
    if (weights_valid && !wv_d) begin
      check("iss_expected", 32'(exp_iss.size() != 0), 32'd1);
      if (exp_iss.size() != 0) check("iss_idx", 32'(filter_idx), exp_iss.pop_front());
    end
    if (done) begin
      check("done_expected", 32'(exp_done.size() != 0), 32'd1);
      if (exp_done.size() != 0) check("done_idx", 32'(filter_idx), exp_done.pop_front());
      check("done_busy", 32'(busy), 32'd0);
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"}, wb_data_in, 32'd0);
    check({tag, "_ctl"}, 32'({s_ready, wb_write_enable, wb_clear, weights_valid,
                              filter_idx, busy, done, error}), 32'd0);
  endtask

  // Entered at a negedge; leaves at the negedge after the Kth handshake.
  task automatic load_words(input logic [31:0] base, input bit toggle);
    int n = 0;
    int cyc = 0;
    bit hs;
    for (int i = 0; i < K; i++) exp_wr.push_back(base + 32'(i));
    exp_wr.push_back(32'd0);
    while (n < K && cyc < 200) begin
      s_valid = toggle ? ~cyc[0] : 1'b1;
      s_data  = base + 32'(n);
      hs = s_valid && s_ready;
      @(negedge clk);
      if (hs) n++;
      cyc++;
    end
    s_valid = 1'b0;
    s_data  = 32'hDEAD_BEEF;
    check("load_count", 32'(n), 32'(K));
    check("s_ready_low", 32'(s_ready), 32'd0);
  endtask

  task automatic run_job(input int n, input bit toggle, input logic [31:0] base, input int abort_f);
    int nf = (n > 16) ? 16 : n;
    int w;
    bit aborted = 0;
    if (nf == 0) begin
      exp_done.push_back(32'd0);
      start = 1'b1; num_filters = n[4:0];
      @(negedge clk);
      check("nf0_done_early", 32'(done), 32'd0);
      num_filters = 5'd1;              // start during DONE must be ignored
      @(negedge clk);
      start = 1'b0;
      check("nf0_done_2cyc", 32'(done), 32'd1);
    end else begin
      start = 1'b1; num_filters = n[4:0];
      @(negedge clk);
      start = 1'b0;
      for (int f = 0; f < nf; f++) begin
        exp_clr.push_back(32'(f));
        exp_iss.push_back(32'(f));
        load_words(base + 32'(f * 16), toggle);
        w = 0;
        while (!weights_valid && w < 50) begin @(negedge clk); w++; end
        check("issue_seen", 32'(weights_valid), 32'd1);
        if (f == abort_f) begin
          reset = 1'b1;
          @(negedge clk);
          reset = 1'b0;
          check_reset_outputs("abort");
          aborted = 1;
          break;
        end
        start = 1'b1; num_filters = 5'd0;  // start while busy must be ignored
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("wv_hold", 32'(weights_valid), 32'd1);
        if (f == nf - 1) exp_done.push_back(32'd0);
        compute_done = 1'b1;
        @(negedge clk);
        compute_done = 1'b0;
        check("wv_drop", 32'(weights_valid), 32'd0);
      end
    end
    repeat (4) @(negedge clk);
    check("wr_drained", 32'(exp_wr.size()), 32'd0);
    check("clr_drained", 32'(exp_clr.size()), 32'd0);
    check("iss_drained", 32'(exp_iss.size()), 32'd0);
    check("done_drained", 32'(exp_done.size()), 32'd0);
    check("busy_after", 32'(busy), 32'd0);
    if (aborted) check("abort_idx", 32'(filter_idx), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: bench did not reach its end");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; num_filters = '0;
    s_data = '0; s_valid = 1'b0; compute_done = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);
    // compute_done while idle is ignored
    compute_done = 1'b1;
    @(negedge clk);
    compute_done = 1'b0;
    check("idle_busy", 32'(busy), 32'd0);

    run_job(1, 1'b0, 32'd1, -1);            // words 1..9
    run_job(3, 1'b0, 32'hA5A5_0010, -1);
    run_job(2, 1'b1, 32'h0000_0100, -1);    // stalled stream
    run_job(0, 1'b0, 32'd0, -1);
    run_job(3, 1'b0, 32'h0000_0200, 1);     // reset in WAIT_DONE of filter 1
    run_job(1, 1'b0, 32'h0000_0300, -1);    // restarts at filter 0
    run_job(20, 1'b1, 32'h0000_1000, -1);   // clamped to 16 filters

`ifdef WLC_WATCHDOG_EN
    begin
      int cnt = 0;
      hold_nr = 1'b1;
      exp_clr.push_back(32'd0);
      start = 1'b1; num_filters = 5'd1;
      @(negedge clk);
      start = 1'b0;
      load_words(32'h0000_0400, 1'b0);
      @(negedge clk);                       // first WAIT_READY cycle
      while (!error && cnt < 2000) begin @(negedge clk); cnt++; end
      check("wd_cycles", 32'(cnt), 32'd1024);
      check("wd_error", 32'(error), 32'd1);
      check("wd_idle", 32'(busy), 32'd0);
      check("wd_wv", 32'(weights_valid), 32'd0);
      exp_clr.push_back(32'd0);
      start = 1'b1; num_filters = 5'd1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      check("wd_sticky", 32'(error), 32'd1);
      check("wd_restart_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_reset_outputs("wd_reset");
      hold_nr = 1'b0;
      check("wd_clr_drained", 32'(exp_clr.size()), 32'd0);
    end
`else
    check("error_tied0", 32'(error), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
